// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of the combinational instruction ROM: fetch has
// priority, bounded by a burst limit so pending debug reads are never starved.
module inst_rom_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int FETCH_BURST_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i,
    output logic              stallreq_o
);

    localparam logic [3:0] CNT_MAX = 4'(FETCH_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IF   = 2'd1,
        ST_DBG  = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              if_gnt_s, dbg_gnt_s;

    // Per-cycle grant, ROM drive, burst counter and next owner.
    always_comb begin
        if_gnt_s    = 1'b0;
        dbg_gnt_s   = 1'b0;
        rom_ce_o    = 1'b0;
        rom_addr_o  = {ADDR_W{1'b0}};
        burst_cnt_d = burst_cnt_q;
        owner_d     = ST_IDLE;
        if_rdata_d  = if_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        // Fetch yields only once it has used up its burst allowance.
        if (if_req_i && (!dbg_req_i || (burst_cnt_q != CNT_MAX))) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
        end
        dbg_gnt_s = dbg_req_i & ~if_gnt_s;

        if (if_gnt_s) begin
            rom_ce_o   = 1'b1;
            rom_addr_o = if_addr_i;
            owner_d    = ST_IF;
            if_rdata_d = rom_inst_i;
        end else if (dbg_gnt_s) begin
            rom_ce_o    = 1'b1;
            rom_addr_o  = dbg_addr_i;
            owner_d     = ST_DBG;
            dbg_rdata_d = rom_inst_i;
        end else begin
            rom_ce_o   = 1'b0;
            rom_addr_o = {ADDR_W{1'b0}};
            owner_d    = ST_IDLE;
        end

        if (!dbg_req_i || dbg_gnt_s) begin
            burst_cnt_d = 4'd0;
        end else if (if_gnt_s && (burst_cnt_q != CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // State, counter and captured read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= ST_IDLE;
            burst_cnt_q <= 4'd0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dbg_rdata_q <= {DATA_W{1'b0}};
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            if_rdata_q  <= if_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // The owner of last cycle's ROM read is the port whose data is valid now.
    always_comb begin
        if_rvalid_o  = 1'b0;
        dbg_rvalid_o = 1'b0;
        case (owner_q)
            ST_IF:   if_rvalid_o  = 1'b1;
            ST_DBG:  dbg_rvalid_o = 1'b1;
            ST_IDLE: begin
                if_rvalid_o  = 1'b0;
                dbg_rvalid_o = 1'b0;
            end
            default: begin
                if_rvalid_o  = 1'b0;
                dbg_rvalid_o = 1'b0;
            end
        endcase
    end

    assign if_gnt_o    = if_gnt_s;
    assign dbg_gnt_o   = dbg_gnt_s;
    assign if_rdata_o  = if_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign stallreq_o  = if_req_i & ~if_gnt_s;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed and randomized checks of inst_rom_arbiter against a reference model
// of the arbitration rules and a behavioural ROM.
module tb_inst_rom_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dbg_req = 1'b0;
    logic [31:0] if_addr = 32'd0, dbg_addr = 32'd0;
    logic        if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, rom_ce, stallreq;
    logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_inst;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // Reference state.
    int          streak = 0;
    logic        m_ifv = 1'b0, m_dbgv = 1'b0;
    logic [31:0] m_ifd = 32'd0, m_dbgd = 32'd0;
    logic        g_if, g_dbg;

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .FETCH_BURST_MAX(MAX)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
        .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
        .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    assign rom_inst = mem[rom_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_ifv});
        chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_dbgv});
        chk("if_rdata", if_rdata, m_ifd);
        chk("dbg_rdata", dbg_rdata, m_dbgd);
    endtask

    // One cycle: drive requests, check grant/ROM drive, then the response.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da);
        logic        e_if, e_dbg;
        logic [31:0] e_addr;
        @(negedge clk);
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
        #1;
        e_if  = ir && (!dr || streak < MAX);
        e_dbg = dr && !e_if;
        e_addr = e_if ? ia : (e_dbg ? da : 32'd0);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
        chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e_dbg});
        chk("rom_ce", {31'd0, rom_ce}, {31'd0, e_if | e_dbg});
        chk("rom_addr", rom_addr, e_addr);
        chk("stallreq", {31'd0, stallreq}, {31'd0, ir & ~e_if});
        m_ifv  = e_if;
        m_dbgv = e_dbg;
        if (e_if)  m_ifd  = mem[ia[7:2]];
        if (e_dbg) m_dbgd = mem[da[7:2]];
        // Streak = fetch wins since debug was last idle or served.
        if (!dr || e_dbg)   streak = 0;
        else if (e_if)      streak = (streak < MAX) ? streak + 1 : MAX;
        g_if = e_if; g_dbg = e_dbg;
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
        #1;
        m_ifv = 1'b0; m_dbgv = 1'b0; m_ifd = 32'd0; m_dbgd = 32'd0; streak = 0;
        chk_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        p_if, p_dbg;
        logic [31:0] a_if, a_dbg;
        int          dbg_wait;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        do_reset();

        // Sequential fetch with debug idle.
        step(1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 32'h0);

        // Both requesting continuously: IF x4 then DBG, repeating.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h20 + 32'(i * 4), 1'b1, 32'h40);
            chk("burst_pattern_dbg", {31'd0, g_dbg}, {31'd0, (i % 5) == 4});
        end

        // Debug only, then idle with rdata held.
        step(1'b0, 32'h0, 1'b1, 32'h10);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);

        // Same address from both ports.
        step(1'b1, 32'h30, 1'b1, 32'h30);

        // Debug appears then vanishes before service: counter must clear.
        step(1'b1, 32'h4, 1'b1, 32'h8);
        step(1'b1, 32'h8, 1'b1, 32'h8);
        step(1'b1, 32'hc, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50, 1'b1, 32'h60);
        chk("dbg_after_clear", {31'd0, g_dbg}, 32'd1);

        // Reset while an IF response is pending.
        step(1'b1, 32'h14, 1'b0, 32'h0);
        do_reset();
        step(1'b1, 32'h18, 1'b1, 32'h1c);

        // Randomized traffic obeying the hold-until-grant handshake.
        p_if = 1'b0; p_dbg = 1'b0; a_if = 32'd0; a_dbg = 32'd0; dbg_wait = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p_if && ($urandom_range(3, 0) != 0)) begin
                p_if = 1'b1; a_if = 32'($urandom_range(255, 0));
            end
            if (!p_dbg && ($urandom_range(3, 0) == 0)) begin
                p_dbg = 1'b1; a_dbg = 32'($urandom_range(255, 0)); dbg_wait = 0;
            end
            step(p_if, a_if, p_dbg, a_dbg);
            if (p_dbg) begin
                dbg_wait++;
                if (g_dbg) begin
                    chk("dbg_wait_bound", {31'd0, dbg_wait <= MAX + 1}, 32'd1);
                    p_dbg = 1'b0;
                end else if ($urandom_range(15, 0) == 0) begin
                    p_dbg = 1'b0;
                end
            end
            if (g_if) p_if = 1'b0;
            else if (p_if && $urandom_range(15, 0) == 0) p_if = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
